// File: rtl/snake_tick_gen.sv
// Game-tick generator for the VGA snake game: divides clk into a movement tick
// whose interval shrinks per level, with levels advanced by food events.
module snake_tick_gen #(
    parameter int unsigned CNT_W           = 30,
    parameter int unsigned EASY_PERIOD     = 2_500_000,
    parameter int unsigned HARD_PERIOD     = 1_000_000,
    parameter int unsigned STEP            = 100_000,
    parameter int unsigned MIN_PERIOD      = 250_000,
    parameter int unsigned MAX_LEVEL       = 7,
    parameter int unsigned FOODS_PER_LEVEL = 4,
    parameter int unsigned LVL_W           = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             pause,
    input  logic             speed_up,
    input  logic             restart,
    output logic             tick,
    output logic             tick_clk,
    output logic [LVL_W-1:0] level,
    output logic             at_max,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
    localparam int unsigned TGT_W  = CNT_W + LVL_W + 1;

    localparam logic [FOOD_W-1:0] FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);

    // Interval for a given mode/level, clamped to MIN_PERIOD instead of wrapping.
    function automatic logic [CNT_W-1:0] target_of(input logic m, input logic [LVL_W-1:0] lvl);
        logic [TGT_W-1:0] base;
        logic [TGT_W-1:0] dec;
        logic [TGT_W-1:0] floor_v;
        base    = m ? TGT_W'(EASY_PERIOD) : TGT_W'(HARD_PERIOD);
        dec     = TGT_W'(lvl) * TGT_W'(STEP);
        floor_v = TGT_W'(MIN_PERIOD) + dec;
        if (base < floor_v) begin
            return CNT_W'(MIN_PERIOD);
        end
        return CNT_W'(base - dec);
    endfunction

    logic [CNT_W-1:0]  cnt;
    logic [FOOD_W-1:0] food;

    logic [CNT_W-1:0]  cnt_nxt;
    logic [FOOD_W-1:0] food_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [CNT_W-1:0]  period_nxt;
    logic              tick_nxt;
    logic              tick_clk_nxt;
    logic              terminal;
    logic [LVL_W-1:0]  tgt_lvl;
    logic [CNT_W-1:0]  target;

    assign terminal = (cnt == period - CNT_W'(1));
    assign tgt_lvl  = restart ? '0 : level;
    assign target   = target_of(mode, tgt_lvl);
    assign at_max   = (level == LVL_MAX);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            food     <= '0;
            level    <= '0;
            tick     <= 1'b0;
            tick_clk <= 1'b0;
            period   <= CNT_W'(EASY_PERIOD);
        end else begin
            cnt      <= cnt_nxt;
            food     <= food_nxt;
            level    <= level_nxt;
            tick     <= tick_nxt;
            tick_clk <= tick_clk_nxt;
            period   <= period_nxt;
        end
    end

    // Next-state: restart beats pause, pause beats interval end; food counts even when paused.
    always_comb begin
        cnt_nxt      = cnt;
        food_nxt     = food;
        level_nxt    = level;
        period_nxt   = period;
        tick_nxt     = 1'b0;
        tick_clk_nxt = tick_clk;

        if (restart) begin
            cnt_nxt    = '0;
            food_nxt   = '0;
            level_nxt  = '0;
            period_nxt = target;
        end else begin
            if (!pause) begin
                if (terminal) begin
                    cnt_nxt      = '0;
                    tick_nxt     = 1'b1;
                    tick_clk_nxt = ~tick_clk;
                    period_nxt   = target;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            if (speed_up) begin
                if (food == FOOD_LAST) begin
                    food_nxt = '0;
                    if (level != LVL_MAX) begin
                        level_nxt = level + LVL_W'(1);
                    end
                end else begin
                    food_nxt = food + FOOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_tick_gen.sv
// Scoreboard bench for snake_tick_gen: expected ticks are queued from a small
// interval/level model and compared against ticks captured from the DUT.
module tb_snake_tick_gen;

    localparam int unsigned CNT_W = 30;

    typedef struct {
        int               edge_no;
        logic             tclk;
        logic [CNT_W-1:0] per;
        logic [1:0]       lvl;
    } ev_t;

    logic             clk;
    logic             reset;
    logic             mode;
    logic             pause;
    logic             speed_up;
    logic             restart;
    logic             tick;
    logic             tick_clk;
    logic [1:0]       level;
    logic             at_max;
    logic [CNT_W-1:0] period;

    int   checks = 0;
    int   errors = 0;
    int   edge_ctr = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    ev_t  logged;

    int   m_last;
    int   m_per;
    int   m_lvl;
    int   m_food;
    bit   m_mode;
    logic m_tclk;

    snake_tick_gen #(
        .CNT_W(CNT_W), .EASY_PERIOD(10), .HARD_PERIOD(4), .STEP(2),
        .MIN_PERIOD(3), .MAX_LEVEL(3), .FOODS_PER_LEVEL(2)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .pause(pause),
        .speed_up(speed_up), .restart(restart), .tick(tick),
        .tick_clk(tick_clk), .level(level), .at_max(at_max), .period(period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_ctr++;

    // Capture every tick with the state visible just after its edge.
    always @(posedge clk) begin
        #1;
        if (tick === 1'b1) begin
            logged.edge_no = edge_ctr;
            logged.tclk    = tick_clk;
            logged.per     = period;
            logged.lvl     = level;
            obs_q.push_back(logged);
        end
    end

    function automatic int model_target(input bit m, input int lvl);
        int base;
        base = m ? 10 : 4;
        if (base < 3 + lvl * 2) return 3;
        return base - lvl * 2;
    endfunction

    task automatic push_exp(input int extra);
        ev_t e;
        e.edge_no = m_last + m_per + extra;
        e.tclk    = ~m_tclk;
        e.per     = CNT_W'(model_target(m_mode, m_lvl));
        e.lvl     = 2'(m_lvl);
        exp_q.push_back(e);
        m_last = e.edge_no;
        m_per  = model_target(m_mode, m_lvl);
        m_tclk = e.tclk;
    endtask

    task automatic next_tick(output ev_t o, output ev_t e, output bit ok);
        int n;
        n = 0;
        e = exp_q.pop_front();
        ok = 1'b0;
        o.edge_no = -1;
        o.tclk    = 1'bx;
        o.per     = 'x;
        o.lvl     = 'x;
        while (obs_q.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() != 0) begin
            o  = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic pulse_food();
        speed_up = 1'b1;
        @(negedge clk);
        speed_up = 1'b0;
        m_food++;
        if (m_food == 2) begin
            m_food = 0;
            if (m_lvl < 3) m_lvl++;
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_last = edge_ctr;
        m_per  = model_target(m_mode, 0);
        m_lvl  = 0;
        m_food = 0;
    endtask

    task automatic test_reset();
        ev_t o, e;
        bit  ok;
        reset = 1'b1; mode = 1'b1; pause = 1'b0; speed_up = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (tick_clk !== 1'b0) begin errors++; $display("FAIL reset_tick_clk got %b want 0", tick_clk); end
        checks++; if (period !== CNT_W'(10)) begin errors++; $display("FAIL reset_period got %0d want 10", period); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got %b want 0", at_max); end
        reset  = 1'b0;
        m_last = edge_ctr; m_per = 10; m_tclk = 1'b0; m_mode = 1'b1; m_lvl = 0; m_food = 0;
        for (int i = 0; i < 3; i++) begin
            push_exp(0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL easy_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL easy_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.tclk !== e.tclk) begin errors++; $display("FAIL easy_tick_clk got %b want %b", o.tclk, e.tclk); end
                checks++; if (o.per !== e.per) begin errors++; $display("FAIL easy_period got %0d want %0d", o.per, e.per); end
                checks++; if (o.lvl !== e.lvl) begin errors++; $display("FAIL easy_level got %0d want %0d", o.lvl, e.lvl); end
            end
        end
    endtask

    task automatic test_level_progression();
        ev_t o, e;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                pulse_food();
                pulse_food();
                checks++; if (level !== 2'(m_lvl)) begin errors++; $display("FAIL prog_level got %0d want %0d", level, m_lvl); end
                checks++; if (at_max !== (m_lvl == 3)) begin errors++; $display("FAIL prog_at_max got %b want %b", at_max, m_lvl == 3); end
            end
            push_exp(0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL prog_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL prog_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.tclk !== e.tclk) begin errors++; $display("FAIL prog_tick_clk got %b want %b", o.tclk, e.tclk); end
                checks++; if (o.per !== e.per) begin errors++; $display("FAIL prog_period got %0d want %0d", o.per, e.per); end
                checks++; if (o.lvl !== e.lvl) begin errors++; $display("FAIL prog_level_at_tick got %0d want %0d", o.lvl, e.lvl); end
            end
        end
    endtask

    task automatic test_hard_clamp();
        ev_t o, e;
        bit  ok;
        mode = 1'b0; m_mode = 1'b0;
        do_restart();
        checks++; if (period !== CNT_W'(4)) begin errors++; $display("FAIL hard_restart_period got %0d want 4", period); end
        for (int i = 0; i < 4; i++) begin
            pulse_food();
            pulse_food();
            checks++; if (level !== 2'(m_lvl)) begin errors++; $display("FAIL hard_level got %0d want %0d", level, m_lvl); end
            push_exp(0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL hard_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL hard_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.tclk !== e.tclk) begin errors++; $display("FAIL hard_tick_clk got %b want %b", o.tclk, e.tclk); end
                checks++; if (o.per !== e.per) begin errors++; $display("FAIL hard_period got %0d want %0d", o.per, e.per); end
                checks++; if (o.lvl !== e.lvl) begin errors++; $display("FAIL hard_level_at_tick got %0d want %0d", o.lvl, e.lvl); end
            end
        end
    endtask

    task automatic test_pause_terminal();
        ev_t o, e;
        bit  ok;
        mode = 1'b1; m_mode = 1'b1;
        do_restart();
        repeat (9) @(negedge clk);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pause_no_tick got %0d ticks want 0", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            push_exp(i == 0 ? 5 : 0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL pause_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL pause_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.tclk !== e.tclk) begin errors++; $display("FAIL pause_tick_clk got %b want %b", o.tclk, e.tclk); end
                checks++; if (o.per !== e.per) begin errors++; $display("FAIL pause_period got %0d want %0d", o.per, e.per); end
            end
        end
    endtask

    task automatic test_mode_change();
        ev_t o, e;
        bit  ok;
        repeat (3) @(negedge clk);
        mode = 1'b0; m_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_exp(0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL mode_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL mode_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.per !== e.per) begin errors++; $display("FAIL mode_period got %0d want %0d", o.per, e.per); end
            end
        end
    endtask

    task automatic test_restart_reset();
        ev_t o, e;
        bit  ok;
        pause = 1'b1;
        repeat (4) pulse_food();
        checks++; if (level !== 2'(m_lvl)) begin errors++; $display("FAIL pre_restart_level got %0d want %0d", level, m_lvl); end
        restart = 1'b1; speed_up = 1'b1;
        @(negedge clk);
        restart = 1'b0; speed_up = 1'b0; pause = 1'b0;
        m_last = edge_ctr; m_per = model_target(m_mode, 0); m_lvl = 0; m_food = 0;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL restart_level got %0d want 0", level); end
        checks++; if (period !== CNT_W'(4)) begin errors++; $display("FAIL restart_period got %0d want 4", period); end
        checks++; if (tick !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL restart_tick got %b/%0d want 0", tick, obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            push_exp(0);
            next_tick(o, e, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL restart_tick timeout waiting for edge %0d", e.edge_no);
            end else begin
                checks++; if (o.edge_no !== e.edge_no) begin errors++; $display("FAIL restart_tick_edge got %0d want %0d", o.edge_no, e.edge_no); end
                checks++; if (o.tclk !== e.tclk) begin errors++; $display("FAIL restart_tick_clk got %b want %b", o.tclk, e.tclk); end
                checks++; if (o.lvl !== e.lvl) begin errors++; $display("FAIL restart_level_at_tick got %0d want %0d", o.lvl, e.lvl); end
            end
        end
        pause = 1'b1;
        pulse_food();
        pulse_food();
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL pre_reset_level got %0d want 1", level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tick_clk !== 1'b0) begin errors++; $display("FAIL async_tick_clk got %b want 0", tick_clk); end
        checks++; if (period !== CNT_W'(10)) begin errors++; $display("FAIL async_period got %0d want 10", period); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL async_level got %0d want 0", level); end
        checks++; if (at_max !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL async_at_max_tick got %b/%b want 0/0", at_max, tick); end
        pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_level_progression();
        test_hard_clamp();
        test_pause_terminal();
        test_mode_change();
        test_restart_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
